multi_cycle_cpu: RTL and testbench
==================================

# multi_cycle_cpu

Parametrised multi-cycle successor to the single-cycle MIPS-subset core. It executes each instruction over a FETCH/DECODE/EXEC/MEM/WB state machine, with one shared ALU and a configurable datapath width. Instruction and data memories are external and use a req/ack handshake, so wait-state memories are supported. It sits at the top of the CPU hierarchy and drives both memory ports.

## Interface
- DATA_W, 32, register/ALU width (16..64); instruction width fixed at 32
- ADDR_W, 32, PC and memory address width
- RESET_PC, 0, PC value loaded on reset
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, synchronous, active-low
- imem_req_o  output  1  instruction fetch request
- imem_addr_o  output  ADDR_W  fetch address (= PC)
- imem_ack_i  input  1  fetch data valid this cycle
- imem_data_i  input  32  instruction word
- dmem_req_o  output  1  data access request
- dmem_we_o  output  1  1 = store, 0 = load
- dmem_addr_o  output  ADDR_W  data address
- dmem_wdata_o  output  DATA_W  store data (rt)
- dmem_ack_i  input  1  access complete; load data valid
- dmem_rdata_i  input  DATA_W  load data
- retire_o  output  1  one-cycle pulse when an instruction completes
- cycle_cnt_o  output  32  cycle counter (see Configuration)
- instret_o  output  32  retired-instruction counter (see Configuration)

## Operation
- Supported instructions (MIPS encoding):
  - R-type (op 000000): add 100000, sub 100010, and 100100, or 100101, slt 101010
  - addi 001000, slti 001010, beq 000100, bne 000101, lw 100011, sw 101011
- Register file: 32 x DATA_W; $0 reads 0 and ignores writes.
- Immediates are sign-extended to DATA_W.
- Arithmetic wraps mod 2^DATA_W; overflow is ignored.
- slt/slti use a signed compare and write 1 or 0.
- FETCH:
  - Assert imem_req_o with imem_addr_o = PC; hold both until imem_ack_i.
  - On req&&ack: latch IR, set PC <= PC+4 (wraps mod 2^ADDR_W), go to DECODE.
- DECODE (1 cycle): latch A = rs and B = rt from the register file; go to EXEC.
- EXEC (1 cycle):
  - Computes ALU result, branch compare, or address = A + sext(imm).
  - beq/bne: if taken, PC <= PC + (sext(imm) << 2), where PC already holds PC+4 and the offset is truncated/extended to ADDR_W. Then FETCH with a retire pulse.
  - R-type/addi/slti: go to WB.
  - lw/sw: go to MEM.
  - Unknown opcode or funct: executes as a NOP and retires; next state is FETCH.
- MEM:
  - Assert dmem_req_o, with dmem_addr_o = low ADDR_W bits of the address (zero-extended if DATA_W < ADDR_W).
  - dmem_we_o = 1 for sw, 0 for lw; dmem_wdata_o = B.
  - Hold all MEM outputs until dmem_ack_i.
  - On ack: sw retires and goes to FETCH; lw latches dmem_rdata_i and goes to WB.
- WB (1 cycle):
  - Write rd (R-type) or rt (I-type/lw).
  - Pulse retire_o, then go to FETCH.
- Memory port rules:
  - Acks that arrive while the matching req is low are ignored.
  - imem_req_o and dmem_req_o are never high in the same cycle.

## Timing
- Reset values (rst_i low at posedge):
  - State = FETCH, PC = RESET_PC, all registers = 0.
  - All req/we/retire outputs 0; all data/address outputs 0 except imem_addr_o = RESET_PC.
- imem_req_o is first asserted in the cycle after rst_i returns high.
- Reset mid-transaction aborts the instruction: no register write, no retire, any pending ack is discarded.
- Cycles per instruction with zero-wait memory (ack in the same cycle as req):
  - beq/bne: 3
  - R-type/addi/slti: 4
  - sw: 4
  - lw: 5
- Each memory wait cycle adds 1.
- retire_o rises in the cycle the final state (EXEC/MEM/WB) is active; the architectural update is visible on the next edge.
- Register written in WB is visible to the next instruction's DECODE; no hazards exist.

## Configuration
- MULTI_CYCLE_CPU_PERF_EN defined:
  - cycle_cnt_o increments every cycle after reset release.
  - instret_o increments on each retire_o.
  - Both are 0 at reset and wrap at 2^32.
- MULTI_CYCLE_CPU_PERF_EN undefined: cycle_cnt_o and instret_o are tied to 0 and no counter flops are synthesised.

## Test plan
- Reset release, zero-wait memory, program "addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2" -> $3 = 2 after 12 cycles; 3 retire pulses; imem addresses 0, 4, 8.
- imem_ack_i delayed 3 cycles on each fetch -> imem_req_o and imem_addr_o held stable throughout; same final state; each instruction takes 3 extra cycles.
- "sw $3,8($0)" then "lw $4,8($0)" against a memory model, dmem ack after 2 waits -> dmem_we_o = 1, address 8, wdata 2; then $4 = 2; lw takes 7 cycles.
- beq $1,$1,-1 at PC 0x10 -> next fetch address 0x10 (loop); bne $1,$1,+4 -> next fetch address 0x14; each takes 3 cycles.
- slt with $1 = -1, $2 = 1 -> 1; slt with the operands reversed -> 0; addi $0,$0,7 -> $0 stays 0; DATA_W = 16 run: 0x7FFF + 1 -> 0x8000.
- rst_i low during MEM of lw with ack pending -> no write to rt, retire_o stays 0, next fetch at RESET_PC; with MULTI_CYCLE_CPU_PERF_EN, both counters reset to 0.

Source files
------------

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB, shared ALU) with req/ack memory ports.
// Optional cycle/instret counters are built only when MULTI_CYCLE_CPU_PERF_EN is defined.
module multi_cycle_cpu #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_data_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              retire_o,
  output logic [31:0]       cycle_cnt_o,
  output logic [31:0]       instret_o
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_active;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [DATA_W-1:0] r_a, r_b, r_alu, r_mdr;
  logic [DATA_W-1:0] r_regs [32];

  logic [5:0]        w_op, w_funct;
  logic [4:0]        w_rs, w_rt, w_rd, w_dest;
  logic signed [15:0] w_imm;
  logic [DATA_W-1:0] w_sext, w_alu, w_wb_dat;
  logic [ADDR_W-1:0] w_br_off;
  logic              w_is_r, w_is_addi, w_is_slti, w_is_beq, w_is_bne, w_is_lw, w_is_sw;
  logic              w_is_alu, w_taken, w_retire;
  logic              w_unused_shamt;

  assign w_op      = r_ir[31:26];
  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_rd      = r_ir[15:11];
  assign w_funct   = r_ir[5:0];
  assign w_imm     = r_ir[15:0];
  assign w_sext    = DATA_W'(w_imm);
  assign w_br_off  = ADDR_W'(w_imm) << 2;
  assign w_unused_shamt = ^r_ir[10:6];

  assign w_is_addi = (w_op == 6'b001000);
  assign w_is_slti = (w_op == 6'b001010);
  assign w_is_beq  = (w_op == 6'b000100);
  assign w_is_bne  = (w_op == 6'b000101);
  assign w_is_lw   = (w_op == 6'b100011);
  assign w_is_sw   = (w_op == 6'b101011);
  assign w_is_alu  = w_is_r | w_is_addi | w_is_slti;
  assign w_taken   = (w_is_beq && (r_a == r_b)) || (w_is_bne && (r_a != r_b));
  assign w_dest    = w_is_r ? w_rd : w_rt;
  assign w_wb_dat  = w_is_lw ? r_mdr : r_alu;

  always_comb begin
    w_is_r = 1'b0;
    if (w_op == 6'b000000) begin
      case (w_funct)
        6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: w_is_r = 1'b1;
        default: w_is_r = 1'b0;
      endcase
    end
  end

  // Default result is A + sext(imm): serves addi and the lw/sw address.
  always_comb begin
    w_alu = r_a + w_sext;
    if (w_is_r) begin
      case (w_funct)
        6'b100000: w_alu = r_a + r_b;
        6'b100010: w_alu = r_a - r_b;
        6'b100100: w_alu = r_a & r_b;
        6'b100101: w_alu = r_a | r_b;
        default:   w_alu = DATA_W'($signed(r_a) < $signed(r_b));
      endcase
    end else if (w_is_slti) begin
      w_alu = DATA_W'($signed(r_a) < $signed(w_sext));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= S_FETCH;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    imem_req_o   = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req_o = r_active;
        if (r_active && imem_ack_i) w_state_nxt = S_DECODE;
      end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_is_alu) begin
          w_state_nxt = S_WB;
        end else if (w_is_lw || w_is_sw) begin
          w_state_nxt = S_MEM;
        end else begin
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = w_is_sw;
        dmem_addr_o  = ADDR_W'(r_alu);
        dmem_wdata_o = r_b;
        if (dmem_ack_i) begin
          w_retire    = w_is_sw;
          w_state_nxt = w_is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        w_retire    = 1'b1;
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // A reset arriving in the final cycle aborts the instruction, so no retire is reported.
  assign retire_o    = w_retire & rst_i;
  assign imem_addr_o = r_pc;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_pc  <= RESET_PC;
      r_ir  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_alu <= '0;
      r_mdr <= '0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_req_o && imem_ack_i) begin
            r_ir <= imem_data_i;
            r_pc <= r_pc + ADDR_W'(4);
          end
        end
        S_DECODE: begin
          r_a <= r_regs[w_rs];
          r_b <= r_regs[w_rt];
        end
        S_EXEC: begin
          r_alu <= w_alu;
          if (w_taken) r_pc <= r_pc + w_br_off;
        end
        S_MEM: begin
          if (dmem_ack_i && !w_is_sw) r_mdr <= dmem_rdata_i;
        end
        S_WB: begin
          if (w_dest != 5'd0) r_regs[w_dest] <= w_wb_dat;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTI_CYCLE_CPU_PERF_EN
  logic [31:0] r_cycle_cnt, r_instret;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cycle_cnt <= '0;
      r_instret   <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (retire_o) r_instret <= r_instret + 32'd1;
    end
  end

  assign cycle_cnt_o = r_cycle_cnt;
  assign instret_o   = r_instret;
`else
  assign cycle_cnt_o = '0;
  assign instret_o   = '0;
`endif
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Bench for multi_cycle_cpu: small programs in an imem model, stores and fetch addresses scoreboarded.
module tb_multi_cycle_cpu;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_NOR = 6'b100111;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_LW = 6'b100011, OP_SW = 6'b101011;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_o, imem_ack_i;
  logic [31:0] imem_addr_o, imem_data_i;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic        retire_o;
  logic [31:0] cycle_cnt_o, instret_o;

  multi_cycle_cpu dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .retire_o(retire_o), .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
  typedef struct {
    logic [15:0] a; logic [15:0] b; logic [31:0] op_instr; logic [4:0] st_reg; logic [31:0] exp; int cycles;
  } vec_t;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  st_t         sb_store [$];
  logic [31:0] sb_fetch [$];
  vec_t        vecs [11];

  int tests = 0, fails = 0;
  int iwait = 0, dwait = 0;
  bit spurious = 0, unstable = 0, both_hi = 0;
  int cyc = 0, first_req = -1, retires = 0, last_ret = 0;
  logic [31:0] snap_cc, snap_ir;

  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {6'd0, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rs,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'd0;
      dmem[i] = 32'd0;
    end
    sb_store.delete();
    sb_fetch.delete();
  endtask

  // Instruction memory: ack after iwait stall cycles; optionally acks while req is low.
  initial begin
    int   i_cnt;
    logic [31:0] i_addr0;
    i_cnt = 0;
    i_addr0 = 0;
    imem_ack_i = 1'b0;
    imem_data_i = 32'd0;
    forever begin
      @(negedge clk);
      if (imem_req_o) begin
        if (i_cnt == 0) i_addr0 = imem_addr_o;
        else if (imem_addr_o !== i_addr0) unstable = 1;
        if (i_cnt == iwait) begin
          imem_ack_i  = 1'b1;
          imem_data_i = imem[imem_addr_o[9:2]];
          i_cnt = 0;
          if (sb_fetch.size() > 0) chk("fetch_addr", imem_addr_o, sb_fetch.pop_front());
        end else begin
          imem_ack_i  = 1'b0;
          imem_data_i = $urandom;
          i_cnt++;
        end
      end else begin
        i_cnt = 0;
        imem_ack_i  = spurious;
        imem_data_i = $urandom;
      end
    end
  end

  initial begin
    int   d_cnt;
    logic [31:0] d_addr0, d_wd0;
    logic d_we0;
    st_t  e;
    d_cnt = 0;
    d_addr0 = 0;
    d_wd0 = 0;
    d_we0 = 0;
    dmem_ack_i = 1'b0;
    dmem_rdata_i = 32'd0;
    forever begin
      @(negedge clk);
      if (dmem_req_o) begin
        if (d_cnt == 0) begin
          d_addr0 = dmem_addr_o; d_we0 = dmem_we_o; d_wd0 = dmem_wdata_o;
        end else if (dmem_addr_o !== d_addr0 || dmem_we_o !== d_we0 || dmem_wdata_o !== d_wd0) begin
          unstable = 1;
        end
        if (d_cnt == dwait) begin
          dmem_ack_i = 1'b1;
          d_cnt = 0;
          if (dmem_we_o) begin
            dmem[dmem_addr_o[9:2]] = dmem_wdata_o;
            dmem_rdata_i = $urandom;
            if (sb_store.size() == 0) begin
              tests++; fails++;
              $display("FAIL store_extra: got store 0x%0h to 0x%0h, expected none", dmem_wdata_o, dmem_addr_o);
            end else begin
              e = sb_store.pop_front();
              chk("store_addr", dmem_addr_o, e.addr);
              chk("store_data", dmem_wdata_o, e.data);
            end
          end else begin
            dmem_rdata_i = dmem[dmem_addr_o[9:2]];
          end
        end else begin
          dmem_ack_i = 1'b0;
          dmem_rdata_i = $urandom;
          d_cnt++;
        end
      end else begin
        d_cnt = 0;
        dmem_ack_i = spurious;
        dmem_rdata_i = $urandom;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_i) begin
        cyc = 0; first_req = -1; retires = 0; last_ret = 0;
      end else begin
        cyc++;
        if (imem_req_o && first_req < 0) first_req = cyc;
        if (imem_req_o && dmem_req_o) both_hi = 1;
        if (retire_o) begin
          retires++; last_ret = cyc; snap_cc = cycle_cnt_o; snap_ir = instret_o;
        end
      end
    end
  end

  // Expects rst_i low on entry; runs until n retires, then leaves rst_i low.
  task automatic run_prog(input string tag, input int n, input int iw, input int dw, input int exp_cyc,
                          input bit spur);
    int guard;
    iwait = iw; dwait = dw; spurious = spur;
    repeat (2) @(negedge clk);
    unstable = 0; both_hi = 0;
    rst_i = 1'b1;
    guard = 0;
    while (retires < n && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    if (retires < n) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got %0d retires, expected %0d", tag, retires, n);
    end else begin
      chk({tag, "_retires"}, retires, n);
      chk({tag, "_cycles"}, last_ret - first_req + 1, exp_cyc);
      chk({tag, "_stores_left"}, sb_store.size(), 0);
      chk({tag, "_fetches_left"}, sb_fetch.size(), 0);
      chk({tag, "_unstable"}, unstable, 0);
      chk({tag, "_both_req"}, both_hi, 0);
`ifdef MULTI_CYCLE_CPU_PERF_EN
      chk({tag, "_cycle_cnt"}, snap_cc, last_ret - 1);
      chk({tag, "_instret"}, snap_ir, n - 1);
`endif
    end
    @(negedge clk);
    rst_i = 1'b0;
    spurious = 0;
  endtask

  task automatic load_vec(input vec_t v);
    clear_all();
    imem[0] = enc_i(OP_ADDI, 5'd1, 5'd0, v.a);
    imem[1] = enc_i(OP_ADDI, 5'd2, 5'd0, v.b);
    imem[2] = v.op_instr;
    imem[3] = enc_i(OP_SW, v.st_reg, 5'd0, 16'h0040);
    sb_store.push_back('{32'h40, v.exp});
    for (int k = 0; k < 4; k++) sb_fetch.push_back(32'(k * 4));
  endtask

  initial begin
    rst_i = 1'b0;
    vecs[0]  = '{16'd5,   16'hFFFD, enc_r(F_ADD, 5'd3, 5'd1, 5'd2),        5'd3, 32'd2,          16};
    vecs[1]  = '{16'd5,   16'hFFFD, enc_r(F_SUB, 5'd3, 5'd1, 5'd2),        5'd3, 32'd8,          16};
    vecs[2]  = '{16'd12,  16'd10,   enc_r(F_AND, 5'd3, 5'd1, 5'd2),        5'd3, 32'd8,          16};
    vecs[3]  = '{16'd12,  16'd10,   enc_r(F_OR,  5'd3, 5'd1, 5'd2),        5'd3, 32'd14,         16};
    vecs[4]  = '{16'hFFFF, 16'd1,   enc_r(F_SLT, 5'd3, 5'd1, 5'd2),        5'd3, 32'd1,          16};
    vecs[5]  = '{16'd1,   16'hFFFF, enc_r(F_SLT, 5'd3, 5'd1, 5'd2),        5'd3, 32'd0,          16};
    vecs[6]  = '{16'd100, 16'd0,    enc_i(OP_ADDI, 5'd3, 5'd1, 16'hFF6A),  5'd3, 32'hFFFF_FFCE,  16};
    vecs[7]  = '{16'hFFFB, 16'd0,   enc_i(OP_SLTI, 5'd3, 5'd1, 16'd3),     5'd3, 32'd1,          16};
    vecs[8]  = '{16'd5,   16'd0,    enc_i(OP_SLTI, 5'd3, 5'd1, 16'hFFFD),  5'd3, 32'd0,          16};
    vecs[9]  = '{16'd1,   16'd2,    enc_i(OP_ADDI, 5'd0, 5'd0, 16'd7),     5'd0, 32'd0,          16};
    vecs[10] = '{16'd5,   16'd6,    enc_r(F_NOR, 5'd3, 5'd1, 5'd2),        5'd3, 32'd0,          15};
    clear_all();

    repeat (3) @(negedge clk);
    #3;
    chk("rst_imem_req", imem_req_o, 0);
    chk("rst_imem_addr", imem_addr_o, 0);
    chk("rst_dmem_req", dmem_req_o, 0);
    chk("rst_dmem_we", dmem_we_o, 0);
    chk("rst_dmem_addr", dmem_addr_o, 0);
    chk("rst_dmem_wdata", dmem_wdata_o, 0);
    chk("rst_retire", retire_o, 0);
    chk("rst_cycle_cnt", cycle_cnt_o, 0);
    chk("rst_instret", instret_o, 0);
    @(negedge clk);
    rst_i = 1'b1;
    #3 chk("rel_req_first_cycle", imem_req_o, 0);
    @(negedge clk);
    #3 chk("rel_req_second_cycle", imem_req_o, 1);
    chk("rel_req_addr", imem_addr_o, 0);
    @(negedge clk);
    rst_i = 1'b0;

    for (int v = 0; v < 11; v++) begin
      load_vec(vecs[v]);
      run_prog($sformatf("vec%0d", v), 4, 0, 0, vecs[v].cycles, 0);
    end

    load_vec(vecs[0]);
    run_prog("imem_wait3", 4, 3, 0, 28, 0);
    load_vec(vecs[0]);
    run_prog("spurious_ack", 4, 0, 0, 16, 1);

    clear_all();
    imem[0] = enc_i(OP_ADDI, 5'd3, 5'd0, 16'd2);
    imem[1] = enc_i(OP_SW,   5'd3, 5'd0, 16'd8);
    imem[2] = enc_i(OP_LW,   5'd4, 5'd0, 16'd8);
    imem[3] = enc_i(OP_SW,   5'd4, 5'd0, 16'h0044);
    sb_store.push_back('{32'h8, 32'd2});
    sb_store.push_back('{32'h44, 32'd2});
    for (int k = 0; k < 4; k++) sb_fetch.push_back(32'(k * 4));
    run_prog("ldst_wait2", 4, 0, 2, 23, 0);

    clear_all();
    dmem[8] = 32'h7FFF_FFFF;
    imem[0] = enc_i(OP_LW,   5'd1, 5'd0, 16'h0020);
    imem[1] = enc_i(OP_ADDI, 5'd2, 5'd1, 16'd1);
    imem[2] = enc_i(OP_SW,   5'd2, 5'd0, 16'h0040);
    sb_store.push_back('{32'h40, 32'h8000_0000});
    for (int k = 0; k < 3; k++) sb_fetch.push_back(32'(k * 4));
    run_prog("wrap", 3, 0, 0, 13, 0);

    clear_all();
    imem[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 16'd1);
    imem[1] = enc_i(OP_BEQ,  5'd0, 5'd0, 16'd2);
    imem[4] = enc_i(OP_BEQ,  5'd1, 5'd1, 16'hFFFF);
    sb_fetch.push_back(32'h0); sb_fetch.push_back(32'h4);
    sb_fetch.push_back(32'h10); sb_fetch.push_back(32'h10);
    run_prog("beq_loop", 4, 0, 0, 13, 0);

    clear_all();
    imem[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 16'd1);
    imem[1] = enc_i(OP_BEQ,  5'd0, 5'd0, 16'd2);
    imem[4] = enc_i(OP_BNE,  5'd1, 5'd1, 16'd4);
    imem[5] = enc_i(OP_SW,   5'd1, 5'd0, 16'h0040);
    sb_fetch.push_back(32'h0); sb_fetch.push_back(32'h4);
    sb_fetch.push_back(32'h10); sb_fetch.push_back(32'h14);
    sb_store.push_back('{32'h40, 32'd1});
    run_prog("bne_fall", 4, 0, 0, 14, 0);

    // Abort a load while its ack is on the bus, then confirm a clean restart at RESET_PC.
    clear_all();
    dmem[2] = 32'h55;
    imem[0] = enc_i(OP_LW, 5'd4, 5'd0, 16'd8);
    iwait = 0; dwait = 3;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    begin
      int g;
      g = 0;
      do begin
        @(negedge clk);
        #3;
        g++;
      end while (!dmem_ack_i && g < 200);
      chk("abort_ack_seen", dmem_ack_i, 1);
    end
    rst_i = 1'b0;
    #1 chk("abort_retire", retire_o, 0);
    @(negedge clk);
    #3;
    chk("abort_imem_req", imem_req_o, 0);
    chk("abort_pc", imem_addr_o, 0);
    chk("abort_dmem_req", dmem_req_o, 0);
    chk("abort_cycle_cnt", cycle_cnt_o, 0);
    chk("abort_instret", instret_o, 0);
    imem[0] = enc_i(OP_SW, 5'd4, 5'd0, 16'h0040);
    sb_store.push_back('{32'h40, 32'd0});
    sb_fetch.push_back(32'h0);
    run_prog("after_abort", 1, 0, 0, 4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end
endmodule
